// File: rtl/adxl362_spi_sequencer.sv
// ADXL362 bring-up and periodic X/Y/Z burst reader driving a byte-level SPI shifter through a start/done handshake.
// Define ADXL_TEMP_READ_EN to extend each burst with TL/TH and drive temp_out; otherwise temp_out is tied to zero.
module adxl362_spi_sequencer #(
  parameter int BOOT_WAIT_CYCLES = 1000000,
  parameter int SAMPLE_PERIOD    = 10000000,
  parameter int CS_GAP_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES   = 4096
) (
  input  logic        Clock_100MHz,
  input  logic        Reset,
  input  logic        Enable,
  output logic        spi_start,
  output logic [7:0]  spi_tx_byte,
  input  logic        spi_busy,
  input  logic        spi_done,
  input  logic [7:0]  spi_rx_byte,
  output logic        CS,
  output logic [11:0] accel_x,
  output logic [11:0] accel_y,
  output logic [11:0] accel_z,
  output logic [11:0] temp_out,
  output logic        sample_valid,
  output logic        init_done,
  output logic        spi_error
);

`ifdef ADXL_TEMP_READ_EN
  localparam logic [3:0] RD_LAST = 4'd9;
`else
  localparam logic [3:0] RD_LAST = 4'd7;
`endif

  typedef enum logic [2:0] {RST_WR, BOOT_WAIT, CFG_WR, IDLE, RD_BURST, UPDATE} state_t;
  typedef enum logic [1:0] {PH_GAP, PH_START, PH_WAIT} phase_t;

  state_t      r_state, w_state;
  phase_t      r_phase, w_phase;
  logic [3:0]  r_idx, w_idx;
  logic        r_cs, w_cs;
  logic        r_start, w_start;
  logic [7:0]  r_tx, w_tx;
  logic        r_init, w_init;
  logic        r_err, w_err;
  logic [31:0] r_boot_cnt, w_boot_cnt;
  logic [31:0] r_to_cnt, w_to_cnt;
  logic [31:0] r_gap_cnt, r_tick_cnt;
  logic        w_tick, w_xfer, w_cap;
  logic [3:0]  w_last_idx;
  logic [7:0]  w_byte;
  logic [11:0] r_x, r_y, r_z;
  logic [11:0] r_ax, r_ay, r_az;
  logic        r_sv;

  assign w_xfer     = (r_state == RST_WR) || (r_state == CFG_WR) || (r_state == RD_BURST);
  assign w_last_idx = (r_state == RD_BURST) ? RD_LAST : 4'd2;
  assign w_tick     = r_init && (r_tick_cnt == 32'(SAMPLE_PERIOD - 1));

  always_comb begin
    w_byte = 8'h00;
    case (r_state)
      RST_WR: begin
        case (r_idx)
          4'd0:    w_byte = 8'h0A;
          4'd1:    w_byte = 8'h1F;
          default: w_byte = 8'h52;
        endcase
      end
      CFG_WR: begin
        case (r_idx)
          4'd0:    w_byte = 8'h0A;
          4'd1:    w_byte = 8'h2D;
          default: w_byte = 8'h02;
        endcase
      end
      RD_BURST: begin
        if (r_idx == 4'd0)      w_byte = 8'h0B;
        else if (r_idx == 4'd1) w_byte = 8'h0E;
      end
      default: w_byte = 8'h00;
    endcase
  end

  always_comb begin
    w_state    = r_state;
    w_phase    = r_phase;
    w_idx      = r_idx;
    w_cs       = r_cs;
    w_start    = 1'b0;
    w_tx       = r_tx;
    w_init     = r_init;
    w_err      = r_err;
    w_boot_cnt = r_boot_cnt;
    w_to_cnt   = r_to_cnt;
    w_cap      = 1'b0;
    if (w_xfer) begin
      case (r_phase)
        PH_GAP: begin
          // CS drops here; the first start follows one cycle later from PH_START.
          if (r_gap_cnt >= 32'(CS_GAP_CYCLES - 1)) begin
            w_cs    = 1'b0;
            w_phase = PH_START;
          end
        end
        PH_START: begin
          if (!spi_busy) begin
            w_start  = 1'b1;
            w_tx     = w_byte;
            w_to_cnt = '0;
            w_phase  = PH_WAIT;
          end
        end
        PH_WAIT: begin
          if (spi_done) begin
            w_cap = 1'b1;
            if (r_idx == w_last_idx) begin
              w_cs    = 1'b1;
              w_idx   = 4'd0;
              w_phase = PH_GAP;
              case (r_state)
                RST_WR: begin
                  w_state    = BOOT_WAIT;
                  w_boot_cnt = '0;
                end
                CFG_WR: begin
                  w_state = IDLE;
                  w_init  = 1'b1;
                end
                default: w_state = UPDATE;
              endcase
            end else begin
              w_idx   = r_idx + 4'd1;
              w_phase = PH_START;
            end
          end else if (r_to_cnt >= 32'(TIMEOUT_CYCLES - 1)) begin
            w_err   = 1'b1;
            w_cs    = 1'b1;
            w_init  = 1'b0;
            w_state = RST_WR;
            w_phase = PH_GAP;
            w_idx   = 4'd0;
          end else begin
            w_to_cnt = r_to_cnt + 32'd1;
          end
        end
        default: w_phase = PH_GAP;
      endcase
    end else begin
      case (r_state)
        BOOT_WAIT: begin
          if (r_boot_cnt >= 32'(BOOT_WAIT_CYCLES - 1)) w_state = CFG_WR;
          else w_boot_cnt = r_boot_cnt + 32'd1;
        end
        IDLE:    if (w_tick && Enable) w_state = RD_BURST;
        UPDATE:  w_state = IDLE;
        default: w_state = RST_WR;
      endcase
    end
  end

  always_ff @(posedge Clock_100MHz or posedge Reset) begin
    if (Reset) begin
      r_state    <= RST_WR;
      r_phase    <= PH_GAP;
      r_idx      <= 4'd0;
      r_cs       <= 1'b1;
      r_start    <= 1'b0;
      r_tx       <= 8'h00;
      r_init     <= 1'b0;
      r_err      <= 1'b0;
      r_boot_cnt <= '0;
      r_to_cnt   <= '0;
    end else begin
      r_state    <= w_state;
      r_phase    <= w_phase;
      r_idx      <= w_idx;
      r_cs       <= w_cs;
      r_start    <= w_start;
      r_tx       <= w_tx;
      r_init     <= w_init;
      r_err      <= w_err;
      r_boot_cnt <= w_boot_cnt;
      r_to_cnt   <= w_to_cnt;
    end
  end

  always_ff @(posedge Clock_100MHz or posedge Reset) begin
    if (Reset)                                r_gap_cnt <= '0;
    else if (!r_cs)                           r_gap_cnt <= '0;
    else if (r_gap_cnt < 32'(CS_GAP_CYCLES))  r_gap_cnt <= r_gap_cnt + 32'd1;
  end

  // Sample timebase only free-runs once the sensor is configured.
  always_ff @(posedge Clock_100MHz or posedge Reset) begin
    if (Reset)                  r_tick_cnt <= '0;
    else if (!r_init || w_tick) r_tick_cnt <= '0;
    else                        r_tick_cnt <= r_tick_cnt + 32'd1;
  end

`ifdef ADXL_TEMP_READ_EN
  logic [11:0] r_t, r_temp;
`endif

  always_ff @(posedge Clock_100MHz or posedge Reset) begin
    if (Reset) begin
      r_x <= '0;
      r_y <= '0;
      r_z <= '0;
`ifdef ADXL_TEMP_READ_EN
      r_t <= '0;
`endif
    end else if (w_cap && (r_state == RD_BURST)) begin
      case (r_idx)
        4'd2: r_x[7:0]  <= spi_rx_byte;
        4'd3: r_x[11:8] <= spi_rx_byte[3:0];
        4'd4: r_y[7:0]  <= spi_rx_byte;
        4'd5: r_y[11:8] <= spi_rx_byte[3:0];
        4'd6: r_z[7:0]  <= spi_rx_byte;
        4'd7: r_z[11:8] <= spi_rx_byte[3:0];
`ifdef ADXL_TEMP_READ_EN
        4'd8: r_t[7:0]  <= spi_rx_byte;
        4'd9: r_t[11:8] <= spi_rx_byte[3:0];
`endif
        default: ;
      endcase
    end
  end

  // Outputs only move from UPDATE, so a burst cut short never reaches them.
  always_ff @(posedge Clock_100MHz or posedge Reset) begin
    if (Reset) begin
      r_ax <= '0;
      r_ay <= '0;
      r_az <= '0;
      r_sv <= 1'b0;
`ifdef ADXL_TEMP_READ_EN
      r_temp <= '0;
`endif
    end else begin
      r_sv <= (r_state == UPDATE);
      if (r_state == UPDATE) begin
        r_ax <= r_x;
        r_ay <= r_y;
        r_az <= r_z;
`ifdef ADXL_TEMP_READ_EN
        r_temp <= r_t;
`endif
      end
    end
  end

`ifdef ADXL_TEMP_READ_EN
  assign temp_out = r_temp;
`else
  assign temp_out = 12'h000;
`endif

  assign spi_start    = r_start;
  assign spi_tx_byte  = r_tx;
  assign CS           = r_cs;
  assign accel_x      = r_ax;
  assign accel_y      = r_ay;
  assign accel_z      = r_az;
  assign sample_valid = r_sv;
  assign init_done    = r_init;
  assign spi_error    = r_err;

endmodule

// File: tb/tb_adxl362_spi_sequencer.sv
// Bench for adxl362_spi_sequencer: SPI shifter/sensor model, transaction log and expected-sample model.
`timescale 1ns/1ps
module tb_adxl362_spi_sequencer;
  localparam int BOOT = 200;
  localparam int SP   = 1000;
  localparam int GAP  = 16;
  localparam int TO   = 64;
  localparam int LAT  = 8;
`ifdef ADXL_TEMP_READ_EN
  localparam int RD_LEN = 10;
`else
  localparam int RD_LEN = 8;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic spi_start;
  logic [7:0] spi_tx_byte;
  logic spi_busy = 1'b0;
  logic spi_done = 1'b0;
  logic [7:0] spi_rx_byte = 8'h00;
  logic cs;
  logic [11:0] ax, ay, az, tout;
  logic sv, idone, serr;

  always #5 clk = ~clk;

  adxl362_spi_sequencer #(
    .BOOT_WAIT_CYCLES(BOOT), .SAMPLE_PERIOD(SP), .CS_GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .Clock_100MHz(clk), .Reset(rst), .Enable(en),
    .spi_start(spi_start), .spi_tx_byte(spi_tx_byte), .spi_busy(spi_busy),
    .spi_done(spi_done), .spi_rx_byte(spi_rx_byte), .CS(cs),
    .accel_x(ax), .accel_y(ay), .accel_z(az), .temp_out(tout),
    .sample_valid(sv), .init_done(idone), .spi_error(serr)
  );

  typedef struct {
    logic [15:0][7:0] b;
    int len;
    int gap;
  } txn_t;

  txn_t txn_q[$];
  txn_t cur;
  int cyc = 0;
  int n_chk = 0, n_fail = 0;
  int viol = 0, out_viol = 0;
  int sv_cnt = 0, n_falls = 0;
  int rise_cyc = 0, fall_cyc = 0, last_done_cyc = -10;
  int stall_idx = -1, stall_cyc = -1, last_rd_idx = -1;
  logic [7:0] bd [0:7];
  logic [11:0] exp_x = '0, exp_y = '0, exp_z = '0, exp_t = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [23:0] first3(input txn_t t);
    return {t.b[0], t.b[1], t.b[2]};
  endfunction

  // Expected sample from the sensor's register image: 12-bit field = {H[3:0], L}.
  task automatic model_expect();
    exp_x = {bd[1][3:0], bd[0]};
    exp_y = {bd[3][3:0], bd[2]};
    exp_z = {bd[5][3:0], bd[4]};
`ifdef ADXL_TEMP_READ_EN
    exp_t = {bd[7][3:0], bd[6]};
`else
    exp_t = 12'h000;
`endif
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_x"}, 32'(ax), 32'(exp_x));
    chk({tag, "_y"}, 32'(ay), 32'(exp_y));
    chk({tag, "_z"}, 32'(az), 32'(exp_z));
    chk({tag, "_t"}, 32'(tout), 32'(exp_t));
  endtask

  task automatic wait_sample(input string tag, input int sv0);
    for (int k = 0; k < 3 * SP && sv_cnt == sv0; k++) tick();
    chk({tag, "_arrived"}, 32'(sv_cnt != sv0), 32'd1);
  endtask

  task automatic wait_init(input string tag);
    for (int k = 0; k < 4000 && !idone; k++) tick();
    chk({tag, "_init_done"}, 32'(idone), 32'd1);
  endtask

  // Shifter + sensor model, protocol monitor and transaction logger.
  initial begin : responder
    int cnt;
    logic [7:0] pend, held_tx;
    logic prev_cs, prev_rst;
    logic [47:0] prev_out;
    cnt = 0; pend = 8'h00; held_tx = 8'h00; prev_cs = 1'b1; prev_rst = 1'b1; prev_out = '0;
    cur.b = '0; cur.len = 0; cur.gap = 0;
    forever begin
      @(negedge clk);
      spi_done = 1'b0;
      if (sv) sv_cnt++;
      if (!rst && !prev_rst && !sv && {ax, ay, az, tout} != prev_out) out_viol++;
      prev_out = {ax, ay, az, tout};
      prev_rst = rst;
      if (rst) begin
        spi_busy = 1'b0; cnt = 0; prev_cs = 1'b1; cur.len = 0; rise_cyc = cyc;
      end else begin
        if (prev_cs && !cs) begin
          n_falls++;
          fall_cyc = cyc; cur.b = '0; cur.len = 0; cur.gap = cyc - rise_cyc;
          if (cur.gap < GAP) viol++;
        end
        if (!prev_cs && cs) begin
          txn_q.push_back(cur);
          rise_cyc = cyc; spi_busy = 1'b0; cnt = 0;
        end
        prev_cs = cs;
        if (spi_start) begin
          if (spi_busy || cs || fall_cyc >= cyc || cyc == last_done_cyc + 1) viol++;
          held_tx = spi_tx_byte;
          if (cur.len < 16) cur.b[cur.len] = spi_tx_byte;
          pend = (cur.len >= 2 && cur.len < 10 && cur.b[0] == 8'h0B) ? bd[cur.len - 2] : 8'h00;
          last_rd_idx = (cur.b[0] == 8'h0B) ? cur.len : -1;
          if (stall_idx >= 0 && last_rd_idx == stall_idx) begin
            stall_cyc = cyc; cnt = -1;
          end else cnt = LAT;
          cur.len++;
          spi_busy = 1'b1;
        end else if (spi_busy) begin
          if (spi_tx_byte != held_tx) viol++;
          if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
              spi_done = 1'b1; spi_rx_byte = pend; spi_busy = 1'b0; last_done_cyc = cyc;
            end
          end
        end
      end
    end
  end

  initial begin : main
    int sv0, n0, f0, err_cyc, dmy;
    logic drop;
    for (int i = 0; i < 8; i++) bd[i] = 8'h00;

    // Reset state
    repeat (3) tick();
    chk("rst_cs", 32'(cs), 32'd1);
    chk("rst_start", 32'(spi_start), 32'd0);
    chk("rst_tx", 32'(spi_tx_byte), 32'd0);
    chk("rst_samples", 32'({ax, ay, az} == 36'd0 && tout == 12'd0), 32'd1);
    chk("rst_sv", 32'(sv), 32'd0);
    chk("rst_init", 32'(idone), 32'd0);
    chk("rst_err", 32'(serr), 32'd0);
    rst = 1'b0;

    // Bring-up sequence
    wait_init("boot");
    chk("boot_ntxn", 32'(txn_q.size()), 32'd2);
    if (txn_q.size() >= 2) begin
      chk("boot_rst_bytes", 32'(first3(txn_q[0])), 32'h0A1F52);
      chk("boot_rst_len", 32'(txn_q[0].len), 32'd3);
      chk("boot_cfg_bytes", 32'(first3(txn_q[1])), 32'h0A2D02);
      chk("boot_cfg_len", 32'(txn_q[1].len), 32'd3);
      chk("boot_wait_gap", 32'(txn_q[1].gap >= BOOT && txn_q[1].gap <= BOOT + 4), 32'd1);
    end

    // Directed sample values
    bd[0] = 8'h34; bd[1] = 8'hF2; bd[2] = 8'hFF; bd[3] = 8'h0F;
    bd[4] = 8'h00; bd[5] = 8'h08; bd[6] = 8'h10; bd[7] = 8'h05;
    model_expect();
    sv0 = sv_cnt; en = 1'b1;
    wait_sample("dir", sv0);
    chk("dir_x_const", 32'(ax), 32'h234);
    chk("dir_y_const", 32'(ay), 32'hFFF);
    chk("dir_z_const", 32'(az), 32'h800);
    chk_outputs("dir");
    repeat (5) tick();
    chk("dir_single_pulse", 32'(sv_cnt - sv0), 32'd1);
    if (txn_q.size() > 0) begin
      chk("dir_rd_len", 32'(txn_q[$].len), 32'(RD_LEN));
      chk("dir_rd_cmd", 32'({txn_q[$].b[0], txn_q[$].b[1]}), 32'h0B0E);
      dmy = 0;
      for (int i = 2; i < RD_LEN; i++) dmy |= int'(txn_q[$].b[i]);
      chk("dir_rd_dummy", 32'(dmy), 32'd0);
    end

    // Randomized samples, sometimes dropping Enable mid-burst
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 8; i++) bd[i] = 8'($urandom_range(0, 255));
      model_expect();
      drop = 1'($urandom_range(0, 1));
      sv0 = sv_cnt; en = 1'b1;
      for (int k = 0; k < 2 * SP && cs; k++) tick();
      if (drop) en = 1'b0;
      wait_sample($sformatf("rnd%0d", it), sv0);
      chk_outputs($sformatf("rnd%0d", it));
    end

    // Enable low across three tick periods
    en = 1'b0; repeat (5) tick();
    sv0 = sv_cnt; f0 = n_falls;
    repeat (3 * SP + 50) tick();
    chk("dis_no_cs", 32'(n_falls - f0), 32'd0);
    chk("dis_no_sv", 32'(sv_cnt - sv0), 32'd0);
    chk_outputs("dis_hold");

    // spi_done stalled on the second read byte
    stall_idx = 1; sv0 = sv_cnt; n0 = txn_q.size(); err_cyc = -1; en = 1'b1;
    for (int k = 0; k < 2 * SP + TO + 100 && !serr; k++) tick();
    if (serr) err_cyc = cyc;
    chk("to_err", 32'(serr), 32'd1);
    chk("to_latency", 32'(err_cyc - stall_cyc), 32'(TO));
    chk("to_cs", 32'(cs), 32'd1);
    chk("to_init", 32'(idone), 32'd0);
    stall_idx = -1;
    wait_init("to_reinit");
    chk("to_no_sv", 32'(sv_cnt - sv0), 32'd0);
    chk_outputs("to_hold");
    chk("to_err_sticky", 32'(serr), 32'd1);
    chk("to_ntxn", 32'(txn_q.size() - n0), 32'd3);
    if (txn_q.size() >= n0 + 3) begin
      chk("to_aborted_len", 32'(txn_q[n0].len), 32'd2);
      chk("to_rst_bytes", 32'(first3(txn_q[n0 + 1])), 32'h0A1F52);
      chk("to_cfg_bytes", 32'(first3(txn_q[n0 + 2])), 32'h0A2D02);
    end
    for (int i = 0; i < 8; i++) bd[i] = 8'($urandom_range(0, 255));
    model_expect();
    wait_sample("to_recover", sv0);
    chk_outputs("to_recover");

    // Reset during the fourth data byte
    last_rd_idx = -1; sv0 = sv_cnt;
    for (int k = 0; k < 2 * SP && last_rd_idx != 5; k++) tick();
    chk("mid_reached", 32'(last_rd_idx), 32'd5);
    repeat (3) tick();
    #1 rst = 1'b1;
    #1;
    chk("mid_cs", 32'(cs), 32'd1);
    chk("mid_samples", 32'({ax, ay, az, tout} == 48'd0), 32'd1);
    chk("mid_flags", 32'({sv, idone, serr, spi_start}), 32'd0);
    repeat (3) tick();
    chk("mid_no_sv", 32'(sv_cnt - sv0), 32'd0);
    n0 = txn_q.size(); rst = 1'b0;
    wait_init("mid_reinit");
    if (txn_q.size() >= n0 + 2) begin
      chk("mid_rst_bytes", 32'(first3(txn_q[n0])), 32'h0A1F52);
      chk("mid_cfg_bytes", 32'(first3(txn_q[n0 + 1])), 32'h0A2D02);
    end else chk("mid_ntxn", 32'(txn_q.size() - n0), 32'd2);
    chk("mid_outputs_zero", 32'({ax, ay, az, tout} == 48'd0), 32'd1);

    chk("protocol_violations", 32'(viol), 32'd0);
    chk("output_glitches", 32'(out_viol), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
